// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key cracker.
// Holds the FSM state encoding, printable range and seven-segment glyph constants.
package arc4_pkg;

  localparam int KEY_W = 24;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    LEN         = 4'd1,
    INIT        = 4'd2,
    KSA_RD_I    = 4'd3,
    KSA_RD_J    = 4'd4,
    KSA_WR      = 4'd5,
    PRGA_RD_I   = 4'd6,
    PRGA_RD_J   = 4'd7,
    PRGA_WR     = 4'd8,
    PRGA_RD_PAD = 4'd9,
    PRGA_CHK    = 4'd10,
    NEXT        = 4'd11,
    FOUND       = 4'd12,
    FAIL        = 4'd13
  } state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/task4_hex7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/task4_mem.sv
// Single-port 256x8 RAM with registered read, modelling an altsyncram instance.
// Used both for the S array and for the preloaded ciphertext memory.
module arc4_spram (
  input  logic       clk,
  input  logic [7:0] address,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q
);

  logic [7:0] mem [0:255];

  // Write port plus read-old-data registered read
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

endmodule

// File: rtl/task4.sv
// ARC4 brute-force cracker: walks 24-bit keys from zero until the decrypted
// message is entirely printable ASCII, then shows the key on HEX5..HEX0.
module task4
  import arc4_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  logic clk;
  logic rst_n;
  logic unused_s;

  assign clk      = CLOCK_50;
  assign rst_n    = KEY[3];
  assign unused_s = ^{KEY[2:0], SW};

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [KEY_W-1:0]  key;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [7:0]        k_q, k_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        m_q, m_d;
  logic              ph_q, ph_d;

  logic [7:0]        s_addr_s;
  logic [7:0]        s_wdata_s;
  logic              s_we_s;
  logic [7:0]        s_rd_s;
  logic [7:0]        ct_rd_s;

  logic [7:0]        kb_s;
  logic [7:0]        j_add_s;
  logic [7:0]        j_ksa_s;
  logic [7:0]        p_s;

  logic [5:0][6:0]   seg_s;
  logic [5:0][6:0]   hex_q, hex_d;
  logic [9:0]        ledr_q, ledr_d;

  assign key = key_q;

  arc4_spram s (
    .clk     (clk),
    .address (s_addr_s),
    .data    (s_wdata_s),
    .wren    (s_we_s),
    .q       (s_rd_s)
  );

  // The ciphertext address simply follows k; k is zero until the first PRGA,
  // so the length byte is what the LEN state sees.
  arc4_spram ct (
    .clk     (clk),
    .address (k_q),
    .data    (8'd0),
    .wren    (1'b0),
    .q       (ct_rd_s)
  );

  // Key byte selection cycles with i mod 3, tracked by m
  always_comb begin
    case (m_q)
      2'd0:    kb_s = key_q[23:16];
      2'd1:    kb_s = key_q[15:8];
      default: kb_s = key_q[7:0];
    endcase
  end

  assign j_add_s = j_q + s_rd_s;
  assign j_ksa_s = j_add_s + kb_s;
  assign p_s     = ct_rd_s ^ s_rd_s;

  // Next-state, datapath and S-memory control
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    k_d       = k_q;
    len_d     = len_q;
    m_d       = m_q;
    ph_d      = ph_q;
    s_addr_s  = i_q;
    s_wdata_s = 8'd0;
    s_we_s    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = LEN;
      end
      LEN: begin
        len_d = ct_rd_s;
        i_d   = 8'd0;
        if (ct_rd_s == 8'd0) begin
          state_d = FOUND;
        end else begin
          state_d = INIT;
        end
      end
      INIT: begin
        s_wdata_s = i_q;
        s_we_s    = 1'b1;
        i_d       = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = KSA_RD_I;
          j_d     = 8'd0;
          m_d     = 2'd0;
        end else begin
          state_d = INIT;
        end
      end
      KSA_RD_I: begin
        state_d = KSA_RD_J;
      end
      KSA_RD_J: begin
        si_d     = s_rd_s;
        j_d      = j_ksa_s;
        s_addr_s = j_ksa_s;
        ph_d     = 1'b0;
        state_d  = KSA_WR;
      end
      // Swap takes two write cycles on the single port: S[i] first, then S[j]
      KSA_WR: begin
        s_we_s = 1'b1;
        if (!ph_q) begin
          s_wdata_s = s_rd_s;
          ph_d      = 1'b1;
        end else begin
          s_addr_s  = j_q;
          s_wdata_s = si_q;
          ph_d      = 1'b0;
          i_d       = i_q + 8'd1;
          m_d       = (m_q == 2'd2) ? 2'd0 : m_q + 2'd1;
          if (i_q == 8'hFF) begin
            j_d     = 8'd0;
            k_d     = 8'd1;
            state_d = PRGA_RD_I;
          end else begin
            state_d = KSA_RD_I;
          end
        end
      end
      PRGA_RD_I: begin
        i_d      = i_q + 8'd1;
        s_addr_s = i_q + 8'd1;
        state_d  = PRGA_RD_J;
      end
      PRGA_RD_J: begin
        si_d     = s_rd_s;
        j_d      = j_add_s;
        s_addr_s = j_add_s;
        ph_d     = 1'b0;
        state_d  = PRGA_WR;
      end
      PRGA_WR: begin
        s_we_s = 1'b1;
        if (!ph_q) begin
          sj_d      = s_rd_s;
          s_wdata_s = s_rd_s;
          ph_d      = 1'b1;
        end else begin
          s_addr_s  = j_q;
          s_wdata_s = si_q;
          ph_d      = 1'b0;
          state_d   = PRGA_RD_PAD;
        end
      end
      PRGA_RD_PAD: begin
        s_addr_s = si_q + sj_q;
        state_d  = PRGA_CHK;
      end
      PRGA_CHK: begin
        if (!is_printable(p_s)) begin
          state_d = NEXT;
        end else if (k_q == len_q) begin
          state_d = FOUND;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = PRGA_RD_I;
        end
      end
      NEXT: begin
        i_d = 8'd0;
        if (key_q == {KEY_W{1'b1}}) begin
          state_d = FAIL;
        end else begin
          key_d   = key_q + 24'd1;
          state_d = INIT;
        end
      end
      FOUND: begin
        state_d = FOUND;
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      i_q   <= 8'd0;
      j_q   <= 8'd0;
      si_q  <= 8'd0;
      sj_q  <= 8'd0;
      k_q   <= 8'd0;
      len_q <= 8'd0;
      m_q   <= 2'd0;
      ph_q  <= 1'b0;
    end else begin
      key_q <= key_d;
      i_q   <= i_d;
      j_q   <= j_d;
      si_q  <= si_d;
      sj_q  <= sj_d;
      k_q   <= k_d;
      len_q <= len_d;
      m_q   <= m_d;
      ph_q  <= ph_d;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_hex
    hex7seg u_hex (
      .nibble (key[4*g +: 4]),
      .seg    (seg_s[g])
    );
  end

  // Display and LED selection from the terminal state
  always_comb begin
    hex_d  = {6{SEG_BLANK}};
    ledr_d = 10'd0;
    if (state_q == FOUND) begin
      hex_d     = seg_s;
      ledr_d[0] = 1'b1;
    end else if (state_q == FAIL) begin
      hex_d     = {6{SEG_DASH}};
      ledr_d[1] = 1'b1;
    end else begin
      hex_d  = {6{SEG_BLANK}};
      ledr_d = 10'd0;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q  <= {6{SEG_BLANK}};
      ledr_q <= 10'd0;
    end else begin
      hex_q  <= hex_d;
      ledr_q <= ledr_d;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign LEDR = ledr_q;

endmodule

// File: tb/tb_task4.sv
// Directed bench for the ARC4 cracker: ciphertexts are built with a small
// reference ARC4 model and loaded straight into the ct memory.
module tb_task4;
  import arc4_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY      = 4'b0111;
  logic [9:0] SW       = 10'd0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ct_img  [256];
  logic [7:0] pad_buf [256];

  task4 dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .LEDR     (LEDR)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex(input logic [23:0] k);
    logic [41:0] r;
    for (int g = 0; g < 6; g++) r[g*7 +: 7] = glyph(k[g*4 +: 4]);
    return r;
  endfunction

  function automatic logic [41:0] hex_all();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  // Reference ARC4 keystream: pad_buf[1..n]
  task automatic gen_pad(input logic [23:0] k, input int n);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int a = 0; a < 256; a++) s[a] = a[7:0];
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + s[a] + kb[a % 3];
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 8'd0; j = 8'd0;
    for (int b = 1; b <= n; b++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      pad_buf[b] = s[t];
    end
  endtask

  task automatic build_vec(input logic [23:0] k, input string msg);
    int n = msg.len();
    gen_pad(k, n);
    for (int a = 0; a < 256; a++) ct_img[a] = 8'd0;
    ct_img[0] = n[7:0];
    for (int b = 0; b < n; b++) ct_img[b+1] = msg[b] ^ pad_buf[b+1];
  endtask

  // First key (from zero) that the reference model accepts for ct_img
  task automatic model_first_key(output logic [23:0] fk);
    int n = int'(ct_img[0]);
    logic ok;
    logic [7:0] p;
    fk = 24'hFFFFFF;
    for (int k = 0; k < 4096; k++) begin
      gen_pad(k[23:0], n);
      ok = 1'b1;
      for (int b = 1; b <= n; b++) begin
        p = ct_img[b] ^ pad_buf[b];
        if (p < 8'h20 || p > 8'h7E) ok = 1'b0;
      end
      if (ok) begin
        fk = k[23:0];
        break;
      end
    end
  endtask

  task automatic load_ct();
    for (int a = 0; a < 256; a++) dut.ct.mem[a] = ct_img[a];
  endtask

  task automatic wait_done(input int bound, output int used);
    used = -1;
    for (int c = 0; c < bound; c++) begin
      @(posedge CLOCK_50); #1;
      if (LEDR[1:0] != 2'b00) begin
        used = c + 1;
        break;
      end
    end
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge CLOCK_50); #1;
    end
  endtask

  initial begin
    logic [23:0] exp_key;
    logic [23:0] exp3;
    int used;
    int seen;

    // Reset held: outputs blank, key zero
    for (int a = 0; a < 256; a++) ct_img[a] = 8'd0;
    load_ct();
    KEY = 4'b0111;
    cycles(20);
    chk("rst_hex", {22'd0, hex_all()}, {22'd0, {6{SEG_BLANK}}});
    chk("rst_ledr", {54'd0, LEDR}, 64'd0);
    chk("rst_key", {40'd0, dut.key}, 64'd0);

    // L = 0 succeeds immediately with key 0
    KEY = 4'b1111;
    wait_done(300, used);
    chk("l0_done", {63'd0, used >= 0}, 64'd1);
    chk("l0_key", {40'd0, dut.key}, 64'd0);
    chk("l0_hex", {22'd0, hex_all()}, {22'd0, exp_hex(24'h000000)});
    chk("l0_ledr", {54'd0, LEDR}, 64'd1);

    // "Hello" under key 0x000003
    KEY = 4'b0111;
    build_vec(24'h000003, "Hello");
    model_first_key(exp3);
    load_ct();
    cycles(3);
    chk("h_rst_ledr", {54'd0, LEDR}, 64'd0);
    KEY = 4'b1111;
    wait_done((int'(exp3) + 2) * 1400, used);
    chk("h_done", {63'd0, used >= 0}, 64'd1);
    chk("h_key", {40'd0, dut.key}, {40'd0, exp3});
    chk("h_hex", {22'd0, hex_all()}, {22'd0, exp_hex(exp3)});
    chk("h_ledr", {54'd0, LEDR}, 64'd1);

    // Key 0x00000A: ten rejected keys before it
    KEY = 4'b0111;
    build_vec(24'h00000A, "Hi there!");
    model_first_key(exp_key);
    load_ct();
    cycles(3);
    KEY = 4'b1111;
    wait_done(30000, used);
    chk("a_done", {63'd0, used >= 0}, 64'd1);
    chk("a_fast", {63'd0, used < 30000}, 64'd1);
    chk("a_key", {40'd0, dut.key}, {40'd0, exp_key});
    chk("a_hex0", {57'd0, HEX0}, {57'd0, glyph(exp_key[3:0])});
    chk("a_hex", {22'd0, hex_all()}, {22'd0, exp_hex(exp_key)});

    // Abort mid-search, reload, restart from zero
    KEY = 4'b0111;
    cycles(3);
    KEY = 4'b1111;
    cycles(4000);
    chk("mid_busy_ledr", {54'd0, LEDR}, 64'd0);
    chk("mid_busy_key_nz", {63'd0, dut.key != 24'd0}, 64'd1);
    KEY = 4'b0111;
    #1;
    chk("mid_rst_key", {40'd0, dut.key}, 64'd0);
    build_vec(24'h000003, "Hello");
    load_ct();
    cycles(5);
    chk("mid_rst_hex", {22'd0, hex_all()}, {22'd0, {6{SEG_BLANK}}});
    KEY = 4'b1111;
    cycles(10);
    chk("mid_restart_key", {40'd0, dut.key}, 64'd0);
    wait_done((int'(exp3) + 2) * 1400, used);
    chk("mid_done", {63'd0, used >= 0}, 64'd1);
    chk("mid_key", {40'd0, dut.key}, {40'd0, exp3});
    chk("mid_hex", {22'd0, hex_all()}, {22'd0, exp_hex(exp3)});

    // Exhaustion: jump to 0xFFFFFE with a ciphertext no key accepts
    KEY = 4'b0111;
    for (int a = 0; a < 256; a++) ct_img[a] = 8'd0;
    ct_img[0] = 8'd40;
    load_ct();
    cycles(3);
    KEY = 4'b1111;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLOCK_50);
      if (dut.state_q == INIT) begin
        seen = 1;
        break;
      end
    end
    chk("ex_init_seen", {63'd0, seen == 1}, 64'd1);
    dut.key_q = 24'hFFFFFE;
    wait_done(8000, used);
    chk("ex_done", {63'd0, used >= 0}, 64'd1);
    chk("ex_ledr", {54'd0, LEDR}, 64'd2);
    chk("ex_hex", {22'd0, hex_all()}, {22'd0, {6{SEG_DASH}}});
    chk("ex_key", {40'd0, dut.key}, 64'hFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
